feistel_decrypt: RTL and testbench
==================================

# feistel_decrypt

Blowfish decryption engine that pairs with the encryption Feistel block. It runs the 16 rounds in reverse P-array order, P17 down to P2, and finishes with the P1/P0 whitening. It shares the same two read-only SRAM ports holding the S-boxes and the P-array. Key-schedule logic or the top-level controller start it on a 64-bit block and collect the plaintext on a one-cycle `done` pulse.

## Interface
- `P_ARRAY_OFFSET`, default 1024: SRAM word address of P[0]; P[i] sits at `P_ARRAY_OFFSET+i`.
- `clk`  in  1  clock; everything is on the rising edge.
- `reset_l`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin decryption; sampled only in IDLE.
- `L`, `R`  in  32 each  ciphertext halves; captured on the accepting edge.
- `addr_a`, `addr_b`  out  12 each  SRAM port A/B word address.
- `data_a`, `data_b`  in  32 each  SRAM read data; valid the cycle after the address is driven with cs low.
- `cs_a_l`, `cs_b_l`  out  1 each  chip select, active low.
- `we_a_l`, `we_b_l`  out  1 each  write enable; tied to 1 (read-only).
- `oe_a_l`, `oe_b_l`  out  1 each  output enable; tied to 0.
- `resultL`, `resultR`  out  32 each  plaintext halves; held until the next accepted start.
- `done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in every state except IDLE.
- `start_err`  out  1  sticky protocol-error flag (see Configuration).

## Operation
- SRAM layout: S0 at 0–255, S1 at 256–511, S2 at 512–767, S3 at 768–1023.
- F(x) = ((S0[x[31:24]] + S1[x[23:16]]) ^ S2[x[15:8]]) + S3[x[7:0]]. All additions are 32-bit mod 2^32.
- Algorithm, for i = 17 down to 2:
  - L ^= P[i]; R ^= F(L); swap L and R.
  - After the loop, undo the last swap, then R ^= P[1] and L ^= P[0].
- Net result: `resultL = Rfinal ^ P[0]`, `resultR = Lfinal ^ P[1]`.
- State machine:
  - **IDLE**: cs high, addresses 0. On `start`: capture L/R into working registers, clear round counter rc, drive `addr_a = OFF+17`, go to XORP.
  - **XORP**: `Lw <= Lw ^ data_a`. Drive `addr_a = (Lw^data_a)[31:24]` and `addr_b = 256 + (Lw^data_a)[23:16]`, both combinational. Go to SBOX.
  - **SBOX**: `F_r <= data_a + data_b`. Drive `addr_a = 512 + Lw[15:8]`, `addr_b = 768 + Lw[7:0]`. Go to RND.
  - **RND**: `Lw <= Rw ^ ((F_r ^ data_a) + data_b)`; `Rw <= Lw`.
    - If rc < 15: rc++, drive `addr_a = OFF + 16 - rc`, go to XORP.
    - Else: drive `addr_a = OFF+1`, `addr_b = OFF+0`, go to FINAL.
  - **FINAL**: `resultL <= Rw ^ data_b`; `resultR <= Lw ^ data_a`. Go to DONE.
  - **DONE**: `done = 1`. Go to IDLE.
- cs is low only in cycles that drive a meaningful address.
- `start` outside IDLE is ignored.

## Timing
- Reset values: all outputs 0 except `cs_*_l` = 1 and `we_*_l` = 1; state IDLE; working registers 0.
- Counting the accepting edge as cycle 0: cycles 1–48 are the rounds (3 per round), cycle 49 is FINAL, cycle 50 is DONE.
- `done` is high for exactly cycle 50.
- `resultL`/`resultR` become valid at the edge entering DONE.
- `start` held high continuously is re-accepted in the IDLE cycle after DONE, giving a 51-cycle throughput.
- `reset_l` low mid-operation: immediate return to IDLE with reset values. No `done` is produced.

## Configuration
- Macro: `FEISTEL_DEC_START_ERR_EN`.
- Defined: `start_err` sets when `start` is high while `busy` is high. It stays set until reset.
- Undefined: `start_err` is tied to 0 and no flag logic is built.

## Test plan
- All SRAM words 0, L=0x01234567, R=0x89ABCDEF -> after 50 cycles `resultL`=0x89ABCDEF, `resultR`=0x01234567, `done` high for 1 cycle.
- S-boxes 0, P[0]=0xFFFFFFFF, P[1]=0x0F0F0F0F, other P 0, same input -> `resultL`=0x76543210, `resultR`=0x0E2C4A68.
- Address trace: P[17]=0x11223344, L=0, R=0, OFF=1024:
  - cycle 1: `addr_a`=1041.
  - cycle 2: `addr_a`=17, `addr_b`=290.
  - cycle 3: `addr_a`=563, `addr_b`=836.
  - cycle 4: `addr_a`=1040.
- Random key tables and random blocks: encrypt with the encryption block, then decrypt with this block -> output equals the original L/R for 1000 vectors.
- `reset_l` pulsed low at cycle 20 -> `busy`, `done` and results go to 0 at once; the next start completes correctly.
- With `FEISTEL_DEC_START_ERR_EN` defined, start at cycle 0 and again at cycle 10 -> the second start is ignored, `start_err`=1 from cycle 11, result still correct.

Source files
------------

// File: rtl/feistel_decrypt_if.sv
// Bus bundle for feistel_decrypt: block request/result handshake plus the
// two read-only SRAM ports holding the S-boxes and the P-array.
// slave  : the decryption engine side
// master : controller / SRAM side
interface feistel_decrypt_if;
   // request / result
   logic        start;
   logic [31:0] L;
   logic [31:0] R;
   logic [31:0] resultL;
   logic [31:0] resultR;
   logic        done;
   logic        busy;
   logic        start_err;
   // SRAM port A
   logic [11:0] addr_a;
   logic [31:0] data_a;
   logic        cs_a_l;
   logic        we_a_l;
   logic        oe_a_l;
   // SRAM port B
   logic [11:0] addr_b;
   logic [31:0] data_b;
   logic        cs_b_l;
   logic        we_b_l;
   logic        oe_b_l;

   modport slave (
      input  start, L, R, data_a, data_b,
      output resultL, resultR, done, busy, start_err,
             addr_a, cs_a_l, we_a_l, oe_a_l,
             addr_b, cs_b_l, we_b_l, oe_b_l
   );

   modport master (
      output start, L, R, data_a, data_b,
      input  resultL, resultR, done, busy, start_err,
             addr_a, cs_a_l, we_a_l, oe_a_l,
             addr_b, cs_b_l, we_b_l, oe_b_l
   );
endinterface

// File: rtl/feistel_decrypt.sv
// Blowfish decryption engine: 16 Feistel rounds using P[17] down to P[2],
// then P[1]/P[0] whitening. S-boxes and P-array are read through two
// synchronous read-only SRAM ports (data valid the cycle after the address).
// Each round takes three cycles: XORP -> SBOX -> RND.
// Optional feature macro: FEISTEL_DEC_START_ERR_EN (sticky start-while-busy
// flag on start_err; tied low when undefined).
module feistel_decrypt #(
   parameter int unsigned P_ARRAY_OFFSET = 1024
) (
   input logic               clk,
   input logic               reset_l,
   feistel_decrypt_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_XORP,
      S_SBOX,
      S_RND,
      S_FINAL,
      S_DONE
   } state_t;

   localparam logic [11:0] P_BASE = 12'(P_ARRAY_OFFSET);
   localparam logic [11:0] S1_BASE = 12'd256;
   localparam logic [11:0] S2_BASE = 12'd512;
   localparam logic [11:0] S3_BASE = 12'd768;
   localparam logic [3:0]  LAST_RC = 4'd15;

   state_t      state;
   state_t      state_nx;
   logic [31:0] lw;
   logic [31:0] rw;
   logic [31:0] f_r;
   logic [3:0]  rc;
   logic [31:0] result_l;
   logic [31:0] result_r;

   logic [31:0] lx;
   logic [31:0] f_full;
   logic        accept;
   logic        busy;
   logic        done;
   logic [11:0] addr_a;
   logic [11:0] addr_b;
   logic        cs_a_l;
   logic        cs_b_l;

   // P-array XOR result and completed F() value, shared by FSM and datapath
   always_comb begin
      lx     = lw ^ bus.data_a;
      f_full = (f_r ^ bus.data_a) + bus.data_b;
   end

   // State register
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state, SRAM address/chip-select and status decode
   always_comb begin
      state_nx = state;
      addr_a   = '0;
      addr_b   = '0;
      cs_a_l   = 1'b1;
      cs_b_l   = 1'b1;
      accept   = 1'b0;
      done     = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               accept   = 1'b1;
               addr_a   = P_BASE + 12'd17;
               cs_a_l   = 1'b0;
               state_nx = S_XORP;
            end
         end
         S_XORP: begin
            // S0/S1 indices come straight from the XOR with P, not from lw
            addr_a   = {4'h0, lx[31:24]};
            addr_b   = S1_BASE + {4'h0, lx[23:16]};
            cs_a_l   = 1'b0;
            cs_b_l   = 1'b0;
            state_nx = S_SBOX;
         end
         S_SBOX: begin
            addr_a   = S2_BASE + {4'h0, lw[15:8]};
            addr_b   = S3_BASE + {4'h0, lw[7:0]};
            cs_a_l   = 1'b0;
            cs_b_l   = 1'b0;
            state_nx = S_RND;
         end
         S_RND: begin
            if (rc != LAST_RC) begin
               // next round uses P[16-rc] (rc is the round just finishing)
               addr_a   = P_BASE + 12'd16 - {8'h0, rc};
               cs_a_l   = 1'b0;
               state_nx = S_XORP;
            end else begin
               addr_a   = P_BASE + 12'd1;
               addr_b   = P_BASE;
               cs_a_l   = 1'b0;
               cs_b_l   = 1'b0;
               state_nx = S_FINAL;
            end
         end
         S_FINAL: begin
            state_nx = S_DONE;
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
      busy = (state != S_IDLE);
   end

   // Working halves, round counter and result registers
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         lw       <= '0;
         rw       <= '0;
         f_r      <= '0;
         rc       <= '0;
         result_l <= '0;
         result_r <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  lw <= bus.L;
                  rw <= bus.R;
                  rc <= '0;
               end
            end
            S_XORP: begin
               lw <= lx;
            end
            S_SBOX: begin
               f_r <= bus.data_a + bus.data_b;
            end
            S_RND: begin
               lw <= rw ^ f_full;
               rw <= lw;
               if (rc != LAST_RC) begin
                  rc <= rc + 4'd1;
               end
            end
            S_FINAL: begin
               // last swap undone here: port B holds P[0], port A holds P[1]
               result_l <= rw ^ bus.data_b;
               result_r <= lw ^ bus.data_a;
            end
            default: begin
            end
         endcase
      end
   end

`ifdef FEISTEL_DEC_START_ERR_EN
   logic start_err_q;

   // Sticky flag: start asserted while a block is in flight
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         start_err_q <= 1'b0;
      end else if (bus.start && busy) begin
         start_err_q <= 1'b1;
      end
   end

   assign bus.start_err = start_err_q;
`else
   assign bus.start_err = 1'b0;
`endif

   assign bus.addr_a  = addr_a;
   assign bus.addr_b  = addr_b;
   assign bus.cs_a_l  = cs_a_l;
   assign bus.cs_b_l  = cs_b_l;
   assign bus.we_a_l  = 1'b1;
   assign bus.we_b_l  = 1'b1;
   assign bus.oe_a_l  = 1'b0;
   assign bus.oe_b_l  = 1'b0;
   assign bus.resultL = result_l;
   assign bus.resultR = result_r;
   assign bus.done    = done;
   assign bus.busy    = busy;

endmodule

// File: tb/tb_feistel_decrypt.sv
// Testbench for feistel_decrypt: SRAM model, directed table vectors,
// hand-written timing sequences and random encrypt/decrypt round trips
// against a behavioural Blowfish model.
module tb_feistel_decrypt;

   localparam int OFF = 1024;
`ifdef FEISTEL_DEC_START_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic clk;
   logic reset_l;
   int   n_checks;
   int   n_err;

   feistel_decrypt_if bus ();

   feistel_decrypt #(.P_ARRAY_OFFSET(OFF)) dut (
      .clk     (clk),
      .reset_l (reset_l),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read SRAM, both ports
   logic [31:0] mem [0:4095];
   always @(posedge clk) begin
      if (!bus.cs_a_l) bus.data_a <= mem[bus.addr_a];
      if (!bus.cs_b_l) bus.data_b <= mem[bus.addr_b];
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] pv(input int i);
      return mem[OFF + i];
   endfunction

   function automatic logic [31:0] f_fn(input logic [31:0] x);
      logic [31:0] a, b, c, d;
      a = mem[int'(x[31:24])];
      b = mem[256 + int'(x[23:16])];
      c = mem[512 + int'(x[15:8])];
      d = mem[768 + int'(x[7:0])];
      return ((a + b) ^ c) + d;
   endfunction

   function automatic logic [63:0] bf_encrypt(input logic [63:0] blk);
      logic [31:0] l, r, t;
      l = blk[63:32];
      r = blk[31:0];
      for (int i = 0; i < 16; i++) begin
         l ^= pv(i);
         r ^= f_fn(l);
         t = l; l = r; r = t;
      end
      t = l; l = r; r = t;
      r ^= pv(16);
      l ^= pv(17);
      return {l, r};
   endfunction

   function automatic logic [63:0] bf_decrypt(input logic [63:0] blk);
      logic [31:0] l, r, t;
      l = blk[63:32];
      r = blk[31:0];
      for (int i = 17; i >= 2; i--) begin
         l ^= pv(i);
         r ^= f_fn(l);
         t = l; l = r; r = t;
      end
      t = l; l = r; r = t;
      r ^= pv(1);
      l ^= pv(0);
      return {l, r};
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // mode 0: all zero; 1: S zero, P0/P1 set; 2: only P17 set; 3: random
   task automatic fill_mem(input int mode);
      for (int i = 0; i < 4096; i++) mem[i] = (mode == 3 && i < OFF + 18) ? $urandom : 32'h0;
      if (mode == 1) begin
         mem[OFF + 0] = 32'hFFFF_FFFF;
         mem[OFF + 1] = 32'h0F0F_0F0F;
      end
      if (mode == 2) mem[OFF + 17] = 32'h1122_3344;
   endtask

   // continue counting negedges from lat0 until done or budget spent
   task automatic wait_done(input int lat0, output int lat);
      lat = lat0;
      while (!bus.done && lat < 80) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // start one block; lat = negedges after the accepting edge until done
   task automatic run_block(input logic [31:0] l, input logic [31:0] r,
                            output logic [31:0] gl, output logic [31:0] gr, output int lat);
      @(negedge clk);
      bus.start = 1'b1;
      bus.L = l;
      bus.R = r;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(1, lat);
      gl = bus.resultL;
      gr = bus.resultR;
      check("busy_at_done", {63'h0, bus.busy}, 64'h1);
      @(negedge clk);
      check("done_one_cycle", {63'h0, bus.done}, 64'h0);
   endtask

   typedef struct {
      int          mode;
      logic [31:0] l;
      logic [31:0] r;
      logic [31:0] exp_l;
      logic [31:0] exp_r;
   } vec_t;

   vec_t        vecs [3];
   logic [31:0] gl, gr;
   logic [63:0] pt, ct, ct2;
   int          lat, gap, seen;

   initial begin
      n_checks = 0;
      n_err    = 0;
      vecs[0] = '{0, 32'h0123_4567, 32'h89AB_CDEF, 32'h89AB_CDEF, 32'h0123_4567};
      vecs[1] = '{1, 32'h0123_4567, 32'h89AB_CDEF, 32'h7654_3210, 32'h0E2C_4A68};
      vecs[2] = '{2, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h1122_3344};

      bus.start = 1'b0;
      bus.L = '0;
      bus.R = '0;
      bus.data_a = '0;
      bus.data_b = '0;
      fill_mem(0);
      reset_l = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_busy", {63'h0, bus.busy}, 64'h0);
      check("rst_done", {63'h0, bus.done}, 64'h0);
      check("rst_result", {bus.resultL, bus.resultR}, 64'h0);
      check("rst_cs_we_oe", {58'h0, bus.cs_a_l, bus.cs_b_l, bus.we_a_l, bus.we_b_l, bus.oe_a_l, bus.oe_b_l},
            64'b111100);
      check("rst_addr", {40'h0, bus.addr_a, bus.addr_b}, 64'h0);
      check("rst_start_err", {63'h0, bus.start_err}, 64'h0);
      reset_l = 1'b1;

      // directed table vectors
      for (int v = 0; v < 3; v++) begin
         fill_mem(vecs[v].mode);
         run_block(vecs[v].l, vecs[v].r, gl, gr, lat);
         check($sformatf("vec%0d_result", v), {gl, gr}, {vecs[v].exp_l, vecs[v].exp_r});
         check($sformatf("vec%0d_latency", v), 64'(lat), 64'd50);
      end

      // address trace: only P[17] nonzero, L=R=0
      fill_mem(2);
      @(negedge clk);
      bus.start = 1'b1;
      bus.L = '0;
      bus.R = '0;
      #1;
      check("trace_idle", {51'h0, bus.cs_a_l, bus.addr_a}, {51'h0, 1'b0, 12'd1041});
      @(negedge clk);
      bus.start = 1'b0;
      check("trace_xorp", {40'h0, bus.addr_a, bus.addr_b}, {40'h0, 12'd17, 12'd290});
      @(negedge clk);
      check("trace_sbox", {40'h0, bus.addr_a, bus.addr_b}, {40'h0, 12'd563, 12'd836});
      @(negedge clk);
      check("trace_rnd", {52'h0, bus.addr_a}, {52'h0, 12'd1040});
      wait_done(3, lat);
      check("trace_latency", 64'(lat), 64'd50);
      check("trace_result", {bus.resultL, bus.resultR}, {32'h0, 32'h1122_3344});
      @(negedge clk);

      // random key tables, encrypt with the model, decrypt with the DUT
      for (int k = 0; k < 4; k++) begin
         fill_mem(3);
         for (int n = 0; n < 250; n++) begin
            pt = {$urandom, $urandom};
            ct = bf_encrypt(pt);
            run_block(ct[63:32], ct[31:0], gl, gr, lat);
            check("rand_roundtrip", {gl, gr}, pt);
            if (n == 0) check("rand_latency", 64'(lat), 64'd50);
         end
      end

      // start held high: back-to-back blocks, 51-cycle throughput
      ct  = {$urandom, $urandom};
      ct2 = {$urandom, $urandom};
      @(negedge clk);
      bus.start = 1'b1;
      bus.L = ct[63:32];
      bus.R = ct[31:0];
      @(negedge clk);
      bus.L = ct2[63:32];
      bus.R = ct2[31:0];
      wait_done(1, lat);
      check("b2b_first_latency", 64'(lat), 64'd50);
      check("b2b_first_result", {bus.resultL, bus.resultR}, bf_decrypt(ct));
      @(negedge clk);
      wait_done(1, gap);
      bus.start = 1'b0;
      check("b2b_gap", 64'(gap), 64'd51);
      check("b2b_second_result", {bus.resultL, bus.resultR}, bf_decrypt(ct2));
      @(negedge clk);

      // reset mid-operation
      ct = {$urandom, $urandom};
      @(negedge clk);
      bus.start = 1'b1;
      bus.L = ct[63:32];
      bus.R = ct[31:0];
      @(negedge clk);
      bus.start = 1'b0;
      repeat (19) @(negedge clk);
      reset_l = 1'b0;
      #1;
      check("midrst_busy_done", {62'h0, bus.busy, bus.done}, 64'h0);
      check("midrst_result", {bus.resultL, bus.resultR}, 64'h0);
      check("midrst_cs", {62'h0, bus.cs_a_l, bus.cs_b_l}, 64'h3);
      @(negedge clk);
      reset_l = 1'b1;
      seen = 0;
      for (int c = 0; c < 55; c++) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      check("midrst_no_done", 64'(seen), 64'h0);
      run_block(ct[63:32], ct[31:0], gl, gr, lat);
      check("midrst_next_result", {gl, gr}, bf_decrypt(ct));
      check("midrst_next_latency", 64'(lat), 64'd50);

      // start while busy is ignored; flag only when the feature is built
      ct  = {$urandom, $urandom};
      ct2 = {$urandom, $urandom};
      @(negedge clk);
      bus.start = 1'b1;
      bus.L = ct[63:32];
      bus.R = ct[31:0];
      @(negedge clk);
      bus.start = 1'b0;
      check("serr_before", {63'h0, bus.start_err}, 64'h0);
      repeat (9) @(negedge clk);
      bus.start = 1'b1;
      bus.L = ct2[63:32];
      bus.R = ct2[31:0];
      @(negedge clk);
      bus.start = 1'b0;
      check("serr_after", {63'h0, bus.start_err}, {63'h0, ERR_EN});
      wait_done(11, lat);
      check("serr_latency", 64'(lat), 64'd50);
      check("serr_result", {bus.resultL, bus.resultR}, bf_decrypt(ct));
      repeat (5) @(negedge clk);
      check("serr_sticky", {63'h0, bus.start_err}, {63'h0, ERR_EN});

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
